// File: rtl/hazard_detect_unit_pkg.sv
// Shared pipeline definitions for the stall/flush unit: FSM encodings,
// register-zero constant, control-word constants and the register-match helper.
package hazard_detect_unit_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        FETCH_WAIT = 2'd2
    } hdu_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // ID/EX control word as seen by the datapath; a bubble loads all zeros.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] alu_op;
    } idex_ctrl_t;

    localparam idex_ctrl_t NOP_CTRL = '0;

    // Enables driven by this unit, packed so each pipeline action is one constant.
    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_we;
    } hdu_ctrl_t;

    localparam hdu_ctrl_t CTRL_RESET  = 5'b00110;
    localparam hdu_ctrl_t CTRL_FREEZE = 5'b00000;
    localparam hdu_ctrl_t CTRL_BUBBLE = 5'b00011;
    localparam hdu_ctrl_t CTRL_RUN    = 5'b11001;

    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_detect_unit_cmp.sv
// Register-match logic: load-use hazard against EX, and ID-stage branch
// operand hazard against EX (any writer) and MEM (loads only).
module hazard_cmp
    import hazard_detect_unit_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       id_branch,
    input  logic       idex_memread,
    input  logic       idex_regw,
    input  logic [4:0] idex_rd,
    input  logic       exmem_memread,
    input  logic [4:0] exmem_rd,
    output logic       hz_lu,
    output logic       hz_br
);

    logic ex_hit;
    logic mem_hit;

    always_comb begin
        ex_hit  = reg_match(id_rs, idex_rd)  | (id_uses_rt & reg_match(id_rt, idex_rd));
        mem_hit = reg_match(id_rs, exmem_rd) | (id_uses_rt & reg_match(id_rt, exmem_rd));
        hz_lu   = idex_memread & ex_hit;
        hz_br   = id_branch & ((idex_regw & ex_hit) | (exmem_memread & mem_hit));
    end

endmodule

// File: rtl/hazard_detect_unit.sv
// Stall/flush control for the 5-stage pipeline: freezes on D-cache misses,
// bubbles on I-cache misses and unforwardable hazards, defers branch flushes.
module hazard_detect_unit
    import hazard_detect_unit_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_branch,
    input  logic             branch_taken,
    input  logic             idex_memread,
    input  logic             idex_regw,
    input  logic [4:0]       idex_rd,
    input  logic             exmem_memread,
    input  logic [4:0]       exmem_rd,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_we,
    output logic [CNT_W-1:0] stall_cycles
);

    hdu_state_e       state_q, state_d;
    logic             flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    hdu_ctrl_t        ctrl;
    logic             hz_lu;
    logic             hz_br;

    hazard_cmp u_cmp (
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .id_branch     (id_branch),
        .idex_memread  (idex_memread),
        .idex_regw     (idex_regw),
        .idex_rd       (idex_rd),
        .exmem_memread (exmem_memread),
        .exmem_rd      (exmem_rd),
        .hz_lu         (hz_lu),
        .hz_br         (hz_br)
    );

    always_comb begin
        ctrl         = CTRL_RUN;
        flush_pend_d = flush_pend_q;
        if (!rst_n) begin
            ctrl = CTRL_RESET;
        end else if (dcache_stall) begin
            ctrl = CTRL_FREEZE;
        end else if (icache_stall) begin
            ctrl = CTRL_BUBBLE;
            // In MEM_WAIT the branch in ID has not been released yet, so no flush is owed.
            if (branch_taken && state_q != MEM_WAIT) begin
                flush_pend_d = 1'b1;
            end
        end else if (hz_lu || hz_br) begin
            ctrl = CTRL_BUBBLE;
        end else begin
            ctrl.ifid_flush = branch_taken | flush_pend_q;
            flush_pend_d    = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (dcache_stall)      state_d = MEM_WAIT;
                else if (icache_stall) state_d = FETCH_WAIT;
            end
            MEM_WAIT: begin
                if (!dcache_stall)     state_d = icache_stall ? FETCH_WAIT : RUN;
            end
            FETCH_WAIT: begin
                if (dcache_stall)      state_d = MEM_WAIT;
                else if (!icache_stall) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (rst_n && !ctrl.pc_we && stall_cycles_q != {CNT_W{1'b1}}) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= RUN;
            flush_pend_q   <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            flush_pend_q   <= flush_pend_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign pc_we        = ctrl.pc_we;
    assign ifid_we      = ctrl.ifid_we;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_bubble  = ctrl.idex_bubble;
    assign pipe_we      = ctrl.pipe_we;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Scoreboard bench for hazard_detect_unit: directed pipeline scenarios plus
// random traffic, checked against a rule-level reference model.
module tb_hazard_detect_unit;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic       rst_n;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rt;
        logic       id_branch;
        logic       branch_taken;
        logic       idex_memread;
        logic       idex_regw;
        logic [4:0] idex_rd;
        logic       exmem_memread;
        logic [4:0] exmem_rd;
        logic       icache_stall;
        logic       dcache_stall;
    } stim_t;

    typedef struct {
        logic             pc_we;
        logic             ifid_we;
        logic             ifid_flush;
        logic             idex_bubble;
        logic             pipe_we;
        logic [CNT_W-1:0] cnt;
        int               cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, idex_rd = '0, exmem_rd = '0;
    logic id_uses_rt = 0, id_branch = 0, branch_taken = 0, idex_memread = 0;
    logic idex_regw = 0, exmem_memread = 0, icache_stall = 0, dcache_stall = 0;
    logic pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we;
    logic [CNT_W-1:0] stall_cycles;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cycle = 0;
    bit stim_done = 0;

    // Reference model state: flush owed, stall count, and whether the previous
    // cycle was a D-cache freeze (the pipe is still waiting on memory).
    bit               m_fp = 0;
    logic [CNT_W-1:0] m_cnt = '0;
    bit               m_prev_d = 0;

    always #5 clk = ~clk;

    hazard_detect_unit #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .id_branch     (id_branch),
        .branch_taken  (branch_taken),
        .idex_memread  (idex_memread),
        .idex_regw     (idex_regw),
        .idex_rd       (idex_rd),
        .exmem_memread (exmem_memread),
        .exmem_rd      (exmem_rd),
        .icache_stall  (icache_stall),
        .dcache_stall  (dcache_stall),
        .pc_we         (pc_we),
        .ifid_we       (ifid_we),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .pipe_we       (pipe_we),
        .stall_cycles  (stall_cycles)
    );

    function automatic stim_t idle();
        stim_t s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic bit reads(input stim_t s, input logic [4:0] r);
        return (r != 0) && ((r == s.id_rs) || (s.id_uses_rt && r == s.id_rt));
    endfunction

    task automatic applyStimulus(input stim_t s);
        exp_t e;
        bit   lu, br;
        @(posedge clk);
        #1;
        cycle++;
        rst_n = s.rst_n;           id_rs = s.id_rs;           id_rt = s.id_rt;
        id_uses_rt = s.id_uses_rt; id_branch = s.id_branch;   branch_taken = s.branch_taken;
        idex_memread = s.idex_memread; idex_regw = s.idex_regw; idex_rd = s.idex_rd;
        exmem_memread = s.exmem_memread; exmem_rd = s.exmem_rd;
        icache_stall = s.icache_stall; dcache_stall = s.dcache_stall;

        e.cnt = m_cnt;
        e.cyc = cycle;
        if (!s.rst_n) begin
            {e.pc_we, e.ifid_we, e.ifid_flush, e.idex_bubble, e.pipe_we} = 5'b00110;
            m_cnt = '0; m_fp = 0; m_prev_d = 0;
        end else begin
            lu = s.idex_memread && reads(s, s.idex_rd);
            br = s.id_branch && ((s.idex_regw && reads(s, s.idex_rd)) ||
                                 (s.exmem_memread && reads(s, s.exmem_rd)));
            if (s.dcache_stall) begin
                {e.pc_we, e.ifid_we, e.ifid_flush, e.idex_bubble, e.pipe_we} = 5'b00000;
            end else if (s.icache_stall) begin
                {e.pc_we, e.ifid_we, e.ifid_flush, e.idex_bubble, e.pipe_we} = 5'b00011;
                if (s.branch_taken && !m_prev_d) m_fp = 1;
            end else if (lu || br) begin
                {e.pc_we, e.ifid_we, e.ifid_flush, e.idex_bubble, e.pipe_we} = 5'b00011;
            end else begin
                {e.pc_we, e.ifid_we, e.idex_bubble, e.pipe_we} = 4'b1101;
                e.ifid_flush = s.branch_taken || m_fp;
                m_fp = 0;
            end
            if (!e.pc_we && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
            m_prev_d = s.dcache_stall;
        end
        exp_q.push_back(e);
    endtask

    task automatic checkField(input string name, input int cyc,
                              input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, want);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("pc_we",        e.cyc, 32'(pc_we),        32'(e.pc_we));
        checkField("ifid_we",      e.cyc, 32'(ifid_we),      32'(e.ifid_we));
        checkField("ifid_flush",   e.cyc, 32'(ifid_flush),   32'(e.ifid_flush));
        checkField("idex_bubble",  e.cyc, 32'(idex_bubble),  32'(e.idex_bubble));
        checkField("pipe_we",      e.cyc, 32'(pipe_we),      32'(e.pipe_we));
        checkField("stall_cycles", e.cyc, 32'(stall_cycles), 32'(e.cnt));
    endtask

    // Monitor: compares each queued expectation against the outputs mid-cycle.
    initial begin
        while (!(stim_done && exp_q.size() == 0)) begin
            @(negedge clk);
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: monitor did not drain, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        stim_t s;
        repeat (2) @(posedge clk);

        s = idle(); s.rst_n = 0; applyStimulus(s);
        applyStimulus(idle());

        // lw $2 in EX, add $3,$2,$4 in ID: one bubble, then load moves to MEM
        s = idle(); s.id_rs = 2; s.id_rt = 4; s.id_uses_rt = 1;
        s.idex_memread = 1; s.idex_regw = 1; s.idex_rd = 2; applyStimulus(s);
        s = idle(); s.id_rs = 2; s.id_rt = 4; s.id_uses_rt = 1;
        s.exmem_memread = 1; s.exmem_rd = 2; applyStimulus(s);

        // lw $0 in EX, ID reads $0: no stall
        s = idle(); s.id_uses_rt = 1; s.idex_memread = 1; s.idex_regw = 1; applyStimulus(s);

        // load to $7 while ID only reads rs=$1 and rt=$7 without using rt: no stall
        s = idle(); s.id_rs = 1; s.id_rt = 7; s.idex_memread = 1; s.idex_rd = 7; applyStimulus(s);

        // beq $5,$6 with add $5 in EX: one bubble, then resolve taken
        s = idle(); s.id_branch = 1; s.id_rs = 5; s.id_rt = 6; s.id_uses_rt = 1;
        s.idex_regw = 1; s.idex_rd = 5; s.branch_taken = 1; applyStimulus(s);
        s.idex_regw = 0; s.idex_rd = 0; s.exmem_rd = 5; applyStimulus(s);
        applyStimulus(idle());

        // beq with lw $6 in EX: two bubbles then taken flush
        s = idle(); s.id_branch = 1; s.id_rs = 5; s.id_rt = 6; s.id_uses_rt = 1;
        s.idex_memread = 1; s.idex_regw = 1; s.idex_rd = 6; applyStimulus(s);
        s.idex_memread = 0; s.idex_regw = 0; s.idex_rd = 0;
        s.exmem_memread = 1; s.exmem_rd = 6; applyStimulus(s);
        s.exmem_memread = 0; s.branch_taken = 1; applyStimulus(s);
        applyStimulus(idle());

        // taken branch during a 3-cycle I-cache stall: flush deferred until release
        s = idle(); s.icache_stall = 1; s.branch_taken = 1; applyStimulus(s);
        s.branch_taken = 0; applyStimulus(s); applyStimulus(s);
        applyStimulus(idle());
        applyStimulus(idle());

        // 4-cycle D-cache freeze with a load-use hazard, then the bubble
        s = idle(); s.id_rs = 3; s.idex_memread = 1; s.idex_rd = 3; s.branch_taken = 1;
        s.dcache_stall = 1; s.icache_stall = 1;
        repeat (4) applyStimulus(s);
        s.dcache_stall = 0; s.icache_stall = 0; applyStimulus(s);
        applyStimulus(idle());

        // I-cache miss right after a freeze: no flush owed
        s = idle(); s.dcache_stall = 1; applyStimulus(s);
        s = idle(); s.icache_stall = 1; s.branch_taken = 1; applyStimulus(s);
        applyStimulus(idle());

        // reset in the middle of a freeze, then a deferred flush must work again
        s = idle(); s.dcache_stall = 1; applyStimulus(s); applyStimulus(s);
        s = idle(); s.rst_n = 0; s.dcache_stall = 1; applyStimulus(s);
        s = idle(); s.icache_stall = 1; s.branch_taken = 1; applyStimulus(s);
        applyStimulus(idle());

        // counter saturation: 20 frozen cycles read back as 15
        s = idle(); s.rst_n = 0; applyStimulus(s);
        s = idle(); s.dcache_stall = 1;
        repeat (20) applyStimulus(s);
        applyStimulus(idle());
        applyStimulus(idle());

        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.rst_n         = ($urandom_range(0, 49) != 0);
            s.id_rs         = 5'($urandom_range(0, 3));
            s.id_rt         = 5'($urandom_range(0, 3));
            s.id_uses_rt    = 1'($urandom_range(0, 1));
            s.id_branch     = ($urandom_range(0, 2) == 0);
            s.branch_taken  = ($urandom_range(0, 2) == 0);
            s.idex_memread  = ($urandom_range(0, 2) == 0);
            s.idex_regw     = 1'($urandom_range(0, 1));
            s.idex_rd       = 5'($urandom_range(0, 3));
            s.exmem_memread = ($urandom_range(0, 2) == 0);
            s.exmem_rd      = 5'($urandom_range(0, 3));
            s.icache_stall  = ($urandom_range(0, 4) == 0);
            s.dcache_stall  = ($urandom_range(0, 5) == 0);
            applyStimulus(s);
        end

        stim_done = 1;
    end

endmodule
